// File: rtl/interrupt_request_service.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_request_service
// Purpose  : Interrupt front end of the 8259A-style PIC. This block samples the
//            IR lines into the interrupt request register (IRR) and holds the
//            in-service register (ISR). It also runs the rotating priority
//            resolver that feeds the control logic.
// Revision : 1.0 - initial release
//
// Ports
//   clk                       system clock; all state updates on negedge
//   reset                     asynchronous, active-high
//   init                      ICW_1 write strobe, synchronous re-init
//   LTIM                      1 = level-triggered, 0 = edge-triggered
//   ir_in[7:0]                external IR0..IR7 request lines
//   interrupt_mask[7:0]       IMR, 1 = masked
//   EOI[7:0]                  one-hot ISR bits to clear this cycle
//   freeze                    hold IRR against IR-line changes during INTA
//   latch_in_service          copy current `interrupt` into ISR
//   clear_interrupt_request   IRR bits to clear this cycle
//   priority_rotate[2:0]      lowest-priority level
//   interrupt[7:0]            one-hot winning request, or 0
//   highest_level_in_service  one-hot highest-priority ISR bit, or 0
//   irr[7:0], isr[7:0]        register contents for the read path
//
// Build option
//   IR_INPUT_SYNC_EN : when defined, ir_in goes through a 2-flop negedge
//                      synchroniser. This adds 2 cycles of request latency.
// ============================================================================
module interrupt_request_service #(
  parameter int IR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                LTIM,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] interrupt_mask,
  input  logic [IR_WIDTH-1:0] EOI,
  input  logic                freeze,
  input  logic                latch_in_service,
  input  logic [IR_WIDTH-1:0] clear_interrupt_request,
  input  logic [2:0]          priority_rotate,
  output logic [IR_WIDTH-1:0] interrupt,
  output logic [IR_WIDTH-1:0] highest_level_in_service,
  output logic [IR_WIDTH-1:0] irr,
  output logic [IR_WIDTH-1:0] isr
);

  localparam logic [IR_WIDTH-1:0] ALL_ONES = '1;

  logic [IR_WIDTH-1:0] ir_s;
  logic [IR_WIDTH-1:0] prev_ir;

  // --------------------------------------------------------------------------
  // IR input conditioning
  // --------------------------------------------------------------------------
`ifdef IR_INPUT_SYNC_EN
  logic [IR_WIDTH-1:0] ir_sync1;
  logic [IR_WIDTH-1:0] ir_sync2;

  // Reset to ones so lines already high out of reset do not look like edges.
  // init deliberately leaves these flops alone.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ir_sync1 <= ALL_ONES;
      ir_sync2 <= ALL_ONES;
    end else begin
      ir_sync1 <= ir_in;
      ir_sync2 <= ir_sync1;
    end
  end

  assign ir_s = ir_sync2;
`else
  assign ir_s = ir_in;
`endif

  // --------------------------------------------------------------------------
  // Rotation helpers. The vector is doubled so that a zero shift needs no
  // special case.
  // --------------------------------------------------------------------------
  function automatic logic [IR_WIDTH-1:0] rot_right(input logic [IR_WIDTH-1:0] v,
                                                    input logic [2:0]          n);
    logic [2*IR_WIDTH-1:0] dbl;
    dbl = {v, v} >> n;
    return dbl[IR_WIDTH-1:0];
  endfunction

  function automatic logic [IR_WIDTH-1:0] rot_left(input logic [IR_WIDTH-1:0] v,
                                                   input logic [2:0]          n);
    logic [2*IR_WIDTH-1:0] dbl;
    dbl = {v, v} << n;
    return dbl[2*IR_WIDTH-1:IR_WIDTH];
  endfunction

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [IR_WIDTH-1:0] lowest_bit(input logic [IR_WIDTH-1:0] v);
    return v & (~v + IR_WIDTH'(1));
  endfunction

  // --------------------------------------------------------------------------
  // Priority resolver
  // --------------------------------------------------------------------------
  logic [2:0]          rot_amt;
  logic [IR_WIDTH-1:0] req;
  logic [IR_WIDTH-1:0] req_rot_win;
  logic [IR_WIDTH-1:0] isr_rot_win;
  logic [IR_WIDTH-1:0] req_win;

  // The 3-bit add wraps, which gives (priority_rotate + 1) mod 8.
  assign rot_amt     = priority_rotate + 3'd1;
  assign req         = irr & ~interrupt_mask;
  assign req_rot_win = lowest_bit(rot_right(req, rot_amt));
  assign isr_rot_win = lowest_bit(rot_right(isr, rot_amt));
  assign req_win     = rot_left(req_rot_win, rot_amt);

  assign highest_level_in_service = rot_left(isr_rot_win, rot_amt);

  // Both winners are one-hot in the rotated frame. A numerically smaller
  // value therefore means a strictly higher priority. Requests at or below
  // the current service level are blocked (fully nested mode).
  assign interrupt = ((isr_rot_win == '0) || (req_rot_win < isr_rot_win)) ? req_win : '0;

  // --------------------------------------------------------------------------
  // Next-state terms
  // --------------------------------------------------------------------------
  logic [IR_WIDTH-1:0] irr_set;
  logic [IR_WIDTH-1:0] irr_next;
  logic [IR_WIDTH-1:0] isr_next;

  assign irr_set = LTIM ? ir_s : (~prev_ir & ir_s);

  // A set requires ir_s high, so set and line-low clear never collide. An
  // explicit clear from the control logic overrides everything else.
  assign irr_next = (freeze ? irr : ((irr | irr_set) & ir_s)) & ~clear_interrupt_request;

  // The latch is applied after EOI, so a simultaneous latch wins on that bit.
  assign isr_next = (isr & ~EOI) | (latch_in_service ? interrupt : '0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      irr     <= '0;
      isr     <= '0;
      prev_ir <= ALL_ONES;
    end else if (init) begin
      irr     <= '0;
      isr     <= '0;
      prev_ir <= ALL_ONES;
    end else begin
      prev_ir <= ir_s;
      irr     <= irr_next;
      isr     <= isr_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_request_service.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_request_service
// Purpose  : Directed self-checking bench for interrupt_request_service.
//            The design updates on negedge. Inputs change and outputs are
//            sampled 2 time units after each negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_request_service;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       LTIM;
  logic [7:0] ir_in;
  logic [7:0] interrupt_mask;
  logic [7:0] EOI;
  logic       freeze;
  logic       latch_in_service;
  logic [7:0] clear_interrupt_request;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt;
  logic [7:0] highest_level_in_service;
  logic [7:0] irr;
  logic [7:0] isr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interrupt_request_service #(.IR_WIDTH(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .init                     (init),
    .LTIM                     (LTIM),
    .ir_in                    (ir_in),
    .interrupt_mask           (interrupt_mask),
    .EOI                      (EOI),
    .freeze                   (freeze),
    .latch_in_service         (latch_in_service),
    .clear_interrupt_request  (clear_interrupt_request),
    .priority_rotate          (priority_rotate),
    .interrupt                (interrupt),
    .highest_level_in_service (highest_level_in_service),
    .irr                      (irr),
    .isr                      (isr)
  );

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; LTIM = 1'b0; ir_in = 8'h00;
    interrupt_mask = 8'h00; EOI = 8'h00; freeze = 1'b0;
    latch_in_service = 1'b0; clear_interrupt_request = 8'h00;
    priority_rotate = 3'd7;

    // Reset state
    #1;
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_int", interrupt, 8'h00);
    chk("rst_hlis", highest_level_in_service, 8'h00);
    #6 reset = 1'b0;
    tick();

    // Edge mode: a single rising edge captures the request
    ir_in = 8'h04; tick();
    chk("edge_irr", irr, 8'h04);
    chk("edge_int", interrupt, 8'h04);
    clear_interrupt_request = 8'h04; tick();
    chk("edge_clr", irr, 8'h00);
    clear_interrupt_request = 8'h00; tick();
    chk("edge_noretrig", irr, 8'h00);
    chk("edge_noretrig_int", interrupt, 8'h00);
    ir_in = 8'h00; tick();

    // Level mode: a held line re-requests after a clear
    LTIM = 1'b1; ir_in = 8'h08; tick();
    chk("lvl_irr", irr, 8'h08);
    clear_interrupt_request = 8'h08; tick();
    chk("lvl_clr", irr, 8'h00);
    clear_interrupt_request = 8'h00; tick();
    chk("lvl_reassert", irr, 8'h08);
    ir_in = 8'h00; tick();
    chk("lvl_drop", irr, 8'h00);
    LTIM = 1'b0;

    // Nesting: put IR2 in service, then raise IR0
    ir_in = 8'h04; tick();
    latch_in_service = 1'b1; clear_interrupt_request = 8'h04; tick();
    latch_in_service = 1'b0; clear_interrupt_request = 8'h00;
    chk("nest_isr04", isr, 8'h04);
    chk("nest_hlis04", highest_level_in_service, 8'h04);
    ir_in = 8'h05; tick();
    chk("nest_irr01", irr, 8'h01);
    chk("nest_int01", interrupt, 8'h01);
    // IR0 goes in service and IR2 ends in the same cycle
    latch_in_service = 1'b1; clear_interrupt_request = 8'h01; EOI = 8'h04; tick();
    latch_in_service = 1'b0; clear_interrupt_request = 8'h00; EOI = 8'h00;
    chk("nest_isr01", isr, 8'h01);
    ir_in = 8'h01; tick();
    ir_in = 8'h05; tick();
    chk("nest_irr04", irr, 8'h04);
    chk("nest_blocked", interrupt, 8'h00);
    chk("nest_hlis01", highest_level_in_service, 8'h01);
    EOI = 8'h01; tick();
    EOI = 8'h00;
    chk("nest_eoi_isr", isr, 8'h00);
    chk("nest_eoi_int", interrupt, 8'h04);
    ir_in = 8'h00; clear_interrupt_request = 8'hFF; tick();
    clear_interrupt_request = 8'h00;

    // Rotation and mask
    ir_in = 8'h81; tick();
    chk("rot_irr", irr, 8'h81);
    priority_rotate = 3'd3; #1;
    chk("rot3_int", interrupt, 8'h80);
    interrupt_mask = 8'h80; #1;
    chk("rot3_mask_int", interrupt, 8'h01);
    interrupt_mask = 8'h00;
    priority_rotate = 3'd7; #1;
    chk("rot7_int", interrupt, 8'h01);
    ir_in = 8'h00; tick();

    // Freeze, plus latch and EOI on the same bit
    ir_in = 8'h02; tick();
    chk("frz_pre", irr, 8'h02);
    freeze = 1'b1; ir_in = 8'h00; latch_in_service = 1'b1; EOI = 8'h02; tick();
    latch_in_service = 1'b0; EOI = 8'h00;
    chk("frz_hold", irr, 8'h02);
    chk("frz_latch_eoi", isr, 8'h02);
    clear_interrupt_request = 8'h02; tick();
    chk("frz_clr", irr, 8'h00);
    clear_interrupt_request = 8'h00; freeze = 1'b0;
    EOI = 8'h02; tick();
    EOI = 8'h00;

    // Init
    ir_in = 8'hFF; tick();
    chk("init_pre_irr", irr, 8'hFF);
    interrupt_mask = 8'hEF; #1;
    chk("init_pre_int", interrupt, 8'h10);
    latch_in_service = 1'b1; tick();
    latch_in_service = 1'b0; interrupt_mask = 8'h00;
    chk("init_pre_isr", isr, 8'h10);
    init = 1'b1; tick();
    init = 1'b0;
    chk("init_irr", irr, 8'h00);
    chk("init_isr", isr, 8'h00);
    tick();
    chk("init_no_recap", irr, 8'h00);

    // Asynchronous reset mid-acknowledge
    ir_in = 8'h00; tick();
    ir_in = 8'h08; tick();
    chk("ack_int", interrupt, 8'h08);
    latch_in_service = 1'b1; tick();
    latch_in_service = 1'b0;
    chk("ack_isr", isr, 8'h08);
    #1 reset = 1'b1;
    #1;
    chk("arst_irr", irr, 8'h00);
    chk("arst_isr", isr, 8'h00);
    chk("arst_int", interrupt, 8'h00);
    chk("arst_hlis", highest_level_in_service, 8'h00);
    reset = 1'b0;
    tick();
    chk("arst_no_recap", irr, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_request_service.md
Name: interrupt_request_service

Overview:
- Interrupt front end of the PIC, directly upstream of the control logic.
- Samples the eight IR lines into the interrupt request register (IRR), holds the in-service register (ISR), and runs the rotating priority resolver.
- Drives the control logic's `interrupt` and `highest_level_in_service` inputs.
- Consumes the control logic's `LTIM`, `interrupt_mask`, `EOI`, `freeze`, `latch_in_service`, `clear_interrupt_request` and `priority_rotate` outputs.

Parameters:
- IR_WIDTH, 8, number of request lines; fixed at 8 for 8259A compatibility, other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on negedge clk, matching the control logic
- reset  input  1  asynchronous, active-high
- init  input  1  ICW_1 write strobe; synchronous re-initialisation
- LTIM  input  1  1 = level-triggered, 0 = edge-triggered
- ir_in  input  8  external IR0..IR7 request lines
- interrupt_mask  input  8  IMR; 1 = masked
- EOI  input  8  one-hot ISR bits to clear this cycle
- freeze  input  1  holds IRR against IR-line changes during the acknowledge sequence
- latch_in_service  input  1  copy the current `interrupt` into ISR
- clear_interrupt_request  input  8  IRR bits to clear this cycle
- priority_rotate  input  3  lowest-priority level; highest level is priority_rotate+1 mod 8
- interrupt  output  8  one-hot winning request, or 0
- highest_level_in_service  output  8  one-hot highest-priority ISR bit, or 0
- irr  output  8  IRR contents, for the read path
- isr  output  8  ISR contents, for the read path

Behaviour:
- Reset values: irr = 0, isr = 0, prev_ir = 8'hFF. Outputs interrupt and highest_level_in_service are therefore 0.
- prev_ir reset to all ones so that lines already high at reset are not captured as edges.
- ir_s: ir_in as used internally (raw, or synchronised; see Optional Feature).
- Every negedge, prev_ir <= ir_s.
- IRR set term, per bit n:
  - Edge mode (LTIM=0): set when prev_ir[n]=0 and ir_s[n]=1.
  - Level mode (LTIM=1): set when ir_s[n]=1.
- IRR clear term, per bit n: clear when ir_s[n]=0 (both modes; an edge request must stay high until acknowledge).
- freeze=1: IRR set and clear terms from ir_s are suppressed; prev_ir still updates.
- clear_interrupt_request[n]=1 clears irr[n] regardless of freeze or the set term. This has the highest priority after init.
- init=1:
  - irr <= 0, isr <= 0, prev_ir <= 8'hFF.
  - All other updates are ignored that cycle.
- ISR update: isr_next = (isr & ~EOI) | (latch_in_service ? interrupt : 0).
  - EOI and latch on the same bit in the same cycle: the bit ends up set.
- Priority resolver, combinational from registered state and inputs:
  - req = irr & ~interrupt_mask.
  - Rotate req and isr right by (priority_rotate+1) mod 8, so the highest-priority level lands at bit 0.
  - Take the lowest set bit of each, then rotate back left.
  - The result from req is req_win; the result from isr is highest_level_in_service.
- interrupt = req_win when its rotated index is strictly lower than the rotated index of highest_level_in_service (or ISR is empty); otherwise 0.
  - A request equal to or below the current service level is blocked (fully nested mode).
- Latency: IR rising edge to interrupt non-zero = 1 negedge (3 with the Optional Feature enabled).
- EOI to the next lower request appearing on interrupt = 1 negedge.
- Mask changes and priority_rotate changes take effect combinationally.
- Reset asserted mid-acknowledge: all state clears immediately. Requests still held high need a fresh edge in edge mode.

Optional Feature:
- Macro: IR_INPUT_SYNC_EN.
- Defined: ir_in passes through a 2-flop negedge synchroniser before edge/level detection. Synchroniser flops reset to 8'hFF, and init does not touch them. Adds 2 cycles of request latency.
- Undefined: ir_in is used directly; the integrator guarantees synchronous IR lines.

Test Plan:
- Edge mode, mask=0, rotate=7: ir_in 00->04 -> irr=04 and interrupt=04 after 1 negedge; ir_in held at 04 -> no re-trigger after clear_interrupt_request=04.
- Level mode: ir_in=08 held -> irr=08; clear_interrupt_request=08 pulse -> irr returns to 08 the next cycle; ir_in=00 -> irr=00.
- Nesting: isr=04 and irr=01 -> interrupt=01; isr=01 and irr=04 -> interrupt=00 and highest_level_in_service=01; EOI=01 -> interrupt=04 the next cycle.
- Rotation: priority_rotate=3 and irr=0x81 -> interrupt=0x80 (IR4 highest, so IR7 beats IR0); priority_rotate=7 -> interrupt=0x01.
- Freeze plus simultaneous events: freeze=1, ir_in drops 02->00 -> irr stays 02; latch_in_service and EOI both on bit 1 -> isr bit 1 = 1.
- Init and reset: with irr=0xFF and isr=0x10, init pulse -> irr=0, isr=0, and held-high lines are not recaptured in edge mode; async reset mid-ACK -> all outputs 0 immediately.
